// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN (see dcache_dm_wt).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_e;

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int set_bits,
                                           input int offset_bits);
    return addr >> (set_bits + offset_bits + 2);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int set_bits,
                                           input int offset_bits);
    return (addr >> (offset_bits + 2)) & ((32'd1 << set_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int offset_bits);
    return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_dm_wt_line_store.sv
// Tag, valid and data arrays of the cache: one synchronous write port, one combinational
// read port and a single-cycle invalidate of every line.
module cache_line_store #(
  parameter int DATA_WIDTH  = 32,
  parameter int SET_BITS    = 3,
  parameter int OFFSET_BITS = 1,
  parameter int TAG_BITS    = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_all_i,
  input  logic                   data_we_i,
  input  logic                   tag_we_i,
  input  logic [SET_BITS-1:0]    w_idx_i,
  input  logic [OFFSET_BITS-1:0] w_off_i,
  input  logic [DATA_WIDTH-1:0]  w_data_i,
  input  logic [TAG_BITS-1:0]    w_tag_i,
  input  logic [SET_BITS-1:0]    r_idx_i,
  input  logic [OFFSET_BITS-1:0] r_off_i,
  output logic                   r_valid_o,
  output logic [TAG_BITS-1:0]    r_tag_o,
  output logic [DATA_WIDTH-1:0]  r_data_o
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << (SET_BITS + OFFSET_BITS);

  logic [SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [WORDS];

  // Valid bits: clear wins over a simultaneous line validation.
  always_ff @(posedge clk) begin
    if (rst || clear_all_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[w_idx_i] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (data_we_i) begin
      data_q[{w_idx_i, w_off_i}] <= w_data_i;
    end
    if (tag_we_i) begin
      tag_q[w_idx_i] <= w_tag_i;
    end
  end

  assign r_valid_o = valid_q[r_idx_i];
  assign r_tag_o   = tag_q[r_idx_i];
  assign r_data_o  = data_q[{r_idx_i, r_off_i}];

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack refill FSM.
// Define DCACHE_STATS_EN to add the stat_hits/stat_misses load counters.
module dcache_dm_wt
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SET_BITS    = 3,
  parameter int OFFSET_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int TAG_BITS = 32 - SET_BITS - OFFSET_BITS - 2;
  localparam logic [OFFSET_BITS-1:0] CNT_MAX = {OFFSET_BITS{1'b1}};
  localparam logic [OFFSET_BITS-1:0] CNT_ONE = OFFSET_BITS'(1);

  dcache_state_e           state_q;
  logic [OFFSET_BITS-1:0]  cnt_q;
  logic                    flush_pend_q;
  logic                    wr_done_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [31:0]             mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic [TAG_BITS-1:0]     tag_s;
  logic [SET_BITS-1:0]     idx_s;
  logic [OFFSET_BITS-1:0]  off_s;
  logic                    line_valid_s;
  logic [TAG_BITS-1:0]     line_tag_s;
  logic [DATA_WIDTH-1:0]   line_data_s;
  logic                    hit_s;
  logic                    load_done_s;
  logic                    clear_all_s;
  logic                    data_we_s;
  logic                    tag_we_s;
  logic [OFFSET_BITS-1:0]  w_off_s;
  logic [DATA_WIDTH-1:0]   w_data_s;

  assign tag_s = TAG_BITS'(addr_tag(cpu_addr, SET_BITS, OFFSET_BITS));
  assign idx_s = SET_BITS'(addr_idx(cpu_addr, SET_BITS, OFFSET_BITS));
  assign off_s = OFFSET_BITS'(addr_off(cpu_addr, OFFSET_BITS));

  cache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .SET_BITS   (SET_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .clear_all_i(clear_all_s),
    .data_we_i  (data_we_s),
    .tag_we_i   (tag_we_s),
    .w_idx_i    (idx_s),
    .w_off_i    (w_off_s),
    .w_data_i   (w_data_s),
    .w_tag_i    (tag_s),
    .r_idx_i    (idx_s),
    .r_off_i    (off_s),
    .r_valid_o  (line_valid_s),
    .r_tag_o    (line_tag_s),
    .r_data_o   (line_data_s)
  );

  assign hit_s       = line_valid_s && (line_tag_s == tag_s);
  assign load_done_s = (state_q == IDLE) && cpu_req && !cpu_we && hit_s && !flush;

  // Line-store write controls; a pending flush is applied on the closing ack edge.
  always_comb begin
    clear_all_s = 1'b0;
    data_we_s   = 1'b0;
    tag_we_s    = 1'b0;
    w_off_s     = off_s;
    w_data_s    = cpu_wdata;
    case (state_q)
      IDLE: begin
        clear_all_s = flush;
      end
      REFILL: begin
        if (mem_ack) begin
          data_we_s   = 1'b1;
          w_off_s     = cnt_q;
          w_data_s    = mem_rdata;
          tag_we_s    = (cnt_q == CNT_MAX);
          clear_all_s = (cnt_q == CNT_MAX) && (flush || flush_pend_q);
        end else begin
          data_we_s = 1'b0;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          data_we_s   = hit_s;
          clear_all_s = flush || flush_pend_q;
        end else begin
          data_we_s = 1'b0;
        end
      end
      default: begin
        clear_all_s = 1'b0;
      end
    endcase
  end

  // Zero-latency CPU-side outputs: hit data and stall are combinational.
  always_comb begin
    cpu_rdata = '0;
    cpu_stall = 1'b1;
    if (state_q == IDLE) begin
      if (flush) begin
        cpu_stall = 1'b1;
      end else if (cpu_req && cpu_we) begin
        cpu_stall = !wr_done_q;
      end else if (cpu_req) begin
        cpu_stall = !hit_s;
        cpu_rdata = hit_s ? line_data_s : '0;
      end else begin
        cpu_stall = 1'b0;
      end
    end else begin
      cpu_stall = 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        miss_pend_q;
  logic [31:0] stat_hits_q;
  logic [31:0] stat_misses_q;

  // A load that went through REFILL is scored as a miss when it finally completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_pend_q   <= 1'b0;
      stat_hits_q   <= 32'd0;
      stat_misses_q <= 32'd0;
    end else if (load_done_s) begin
      miss_pend_q <= 1'b0;
      if (miss_pend_q) begin
        stat_misses_q <= stat_misses_q + 32'd1;
      end else begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
    end else if ((state_q == IDLE) && !flush && cpu_req && !cpu_we) begin
      miss_pend_q <= 1'b1;
    end else begin
      miss_pend_q <= miss_pend_q;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`else
  logic unused_load_done_s;
  assign unused_load_done_s = load_done_s;
`endif

  // Control FSM; memory-side outputs are registered and change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      wr_done_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_done_q <= 1'b0;
          if (flush) begin
            state_q <= IDLE;
          end else if (cpu_req && cpu_we && !wr_done_q) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cpu_addr & ~32'd3;
            mem_wdata_q <= cpu_wdata;
          end else if (cpu_req && !cpu_we && !hit_s) begin
            state_q    <= REFILL;
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_s, idx_s, {OFFSET_BITS{1'b0}}, 2'b00};
          end else begin
            state_q <= IDLE;
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_ack && (cnt_q == CNT_MAX)) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
          end else if (mem_ack) begin
            cnt_q      <= cnt_q + CNT_ONE;
            mem_addr_q <= {tag_s, idx_s, cnt_q + CNT_ONE, 2'b00};
          end else begin
            cnt_q <= cnt_q;
          end
        end
        WRITE: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_ack) begin
            state_q      <= IDLE;
            wr_done_q    <= 1'b1;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= '0;
          end else begin
            state_q <= WRITE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
